// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with valid/ready handshakes on both request and result sides.
module riscv_muldiv_unit #(
    parameter int XLEN     = 32,
    parameter bit FAST_DIV = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              special_q, special_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Request decode: operand signedness, magnitudes and RISC-V divide special cases.
    logic              accept;
    logic              a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_res;

    always_comb begin
        accept      = valid_i && (state_q == S_IDLE) && !flush_i;
        a_signed    = op_i[2] ? !op_i[0] : (op_i[1:0] != 2'b11);
        b_signed    = op_i[2] ? !op_i[0] : !op_i[1];
        sa          = a_signed && rs1_i[XLEN-1];
        sb          = b_signed && rs2_i[XLEN-1];
        mag_a       = sa ? -rs1_i : rs1_i;
        mag_b       = sb ? -rs2_i : rs2_i;
        div_zero    = (rs2_i == '0);
        div_ovf     = !op_i[0] && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
        special_res = '0;
        if (div_zero)
            special_res = op_i[1] ? rs1_i : '1;
        else if (div_ovf)
            special_res = op_i[1] ? '0 : rs1_i;
    end

    // One multiply step: conditional add into the high half, then shift the pair right.
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi, mul_lo;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   mul_res;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        mul_hi  = mul_sum[XLEN:1];
        mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
        prod    = {mul_hi, mul_lo};
        prod_s  = neg_q ? -prod : prod;
        mul_res = (op_q == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end

    // One restoring-divide step; the shifted partial remainder needs XLEN+1 bits.
    logic [XLEN:0]     rem_sh;
    logic              qbit;
    logic [XLEN-1:0]   div_hi, div_lo, div_res;

    always_comb begin
        rem_sh  = {hi_q, lo_q[XLEN-1]};
        qbit    = (rem_sh >= {1'b0, opb_q});
        div_hi  = qbit ? (rem_sh[XLEN-1:0] - opb_q) : rem_sh[XLEN-1:0];
        div_lo  = {lo_q[XLEN-2:0], qbit};
        div_res = op_q[1] ? (neg_q ? -div_hi : div_hi) : (neg_q ? -div_lo : div_lo);
    end

    // NOTE: every signal is given its hold value first so no path leaves it unassigned,
    // which is what keeps this block free of inferred latches.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        special_d = special_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opb_d     = opb_q;
        result_d  = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d      = op_i[1:0];
                    cnt_d     = CW'(XLEN);
                    hi_d      = '0;
                    lo_d      = mag_a;
                    opb_d     = mag_b;
                    special_d = 1'b0;
                    if (op_i[2]) begin
                        neg_d     = op_i[1] ? sa : (sa ^ sb);
                        special_d = div_zero || div_ovf;
                        state_d   = S_DIV;
                        if (div_zero || div_ovf) begin
                            result_d = special_res;
                            if (FAST_DIV)
                                state_d = S_DONE;
                        end
                    end else begin
                        neg_d   = sa ^ sb;
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                hi_d  = mul_hi;
                lo_d  = mul_lo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = mul_res;
                    state_d  = S_DONE;
                end
            end
            S_DIV: begin
                hi_d  = div_hi;
                lo_d  = div_lo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    // Special-case results were captured at accept and must survive the iteration.
                    if (!special_q)
                        result_d = div_res;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ready_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i)
            state_d = S_IDLE;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            opb_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            special_q <= special_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
        end
    end

    assign ready_o  = (state_q == S_IDLE);
    assign valid_o  = (state_q == S_DONE);
    assign busy_o   = (state_q != S_IDLE);
    assign result_o = result_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed bench for riscv_muldiv_unit: a FAST_DIV=1 instance for the main sequence and a
// FAST_DIV=0 instance for the iterated special cases.
module tb_riscv_muldiv_unit;

    localparam int XLEN = 32;
    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3,
                           OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            valid_i = 1'b0;
    logic            valid_s = 1'b0;
    logic            ready_i = 1'b1;
    logic            ready_s = 1'b1;
    logic            flush_i = 1'b0;
    logic [2:0]      op_i = '0;
    logic [XLEN-1:0] rs1_i = '0;
    logic [XLEN-1:0] rs2_i = '0;

    logic            f_ready, f_valid, f_busy;
    logic [XLEN-1:0] f_result;
    logic            s_ready, s_valid, s_busy;
    logic [XLEN-1:0] s_result;

    int n_pass  = 0;
    int n_total = 0;

    riscv_muldiv_unit #(.XLEN(XLEN), .FAST_DIV(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(f_ready), .op_i(op_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i), .valid_o(f_valid),
        .ready_i(ready_i), .result_o(f_result), .busy_o(f_busy)
    );

    riscv_muldiv_unit #(.XLEN(XLEN), .FAST_DIV(1'b0)) dut_slow (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_s), .ready_o(s_ready), .op_i(op_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(1'b0), .valid_o(s_valid),
        .ready_i(ready_s), .result_o(s_result), .busy_o(s_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Present a request to the fast unit; returns #1 after the accepting edge (cycle T+1).
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        valid_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!f_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(op, a, b);
        wait_valid(lat);
        check({tag, " result"}, f_result, exp);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        @(posedge clk); #1;
    endtask

    task automatic run_slow(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
        int lat;
        @(negedge clk);
        valid_s = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
        @(posedge clk); #1;
        valid_s = 1'b0;
        lat = 1;
        while (!s_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " result"}, s_result, exp);
        check({tag, " latency"}, 32'(lat), 32'd33);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  lat;
        bit  busy_ok;
        bit  seen;
        logic [31:0] held;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("reset valid_o", 32'(f_valid), 32'd0);
        check("reset ready_o", 32'(f_ready), 32'd1);
        check("reset busy_o", 32'(f_busy), 32'd0);
        check("reset result_o", f_result, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Multiply with busy_o tracked across the whole operation
        issue(OP_MUL, 32'd7, 32'hFFFF_FFFD);
        busy_ok = 1'b1;
        lat = 1;
        while (!f_valid && lat < 100) begin
            if (!f_busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!f_busy) busy_ok = 1'b0;
        check("MUL result", f_result, 32'hFFFF_FFEB);
        check("MUL latency", 32'(lat), 32'd33);
        check("MUL busy held", 32'(busy_ok), 32'd1);
        @(posedge clk); #1;
        check("MUL busy after handshake", 32'(f_busy), 32'd0);

        run_op("MULH", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("MULHU", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("MULHSU", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);

        run_op("DIV", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("REM", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("DIVU", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("REMU", OP_REMU, 32'd100, 32'd7, 32'd2, 33);

        // Fast-path special cases
        run_op("DIVU by 0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("REMU by 0", OP_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_op("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Same special cases through the full iteration
        run_slow("slow DIVU by 0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_slow("slow REMU by 0", OP_REMU, 32'd5, 32'd0, 32'd5);
        run_slow("slow DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_slow("slow REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_slow("slow DIV neg by 0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
        run_slow("slow REM neg by 0", OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);

        // Backpressure: result held for 5 cycles, then next accept one cycle after handshake
        @(negedge clk) ready_i = 1'b0;
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_valid(lat);
        check("BP first result", f_result, 32'd14);
        held = f_result;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("BP valid held", 32'(f_valid), 32'd1);
            check("BP result held", f_result, held);
            check("BP ready_o low", 32'(f_ready), 32'd0);
        end
        @(negedge clk);
        ready_i = 1'b1; valid_i = 1'b1; op_i = OP_MUL; rs1_i = 32'd3; rs2_i = 32'd5;
        @(posedge clk); #1;
        check("BP valid after handshake", 32'(f_valid), 32'd0);
        check("BP ready after handshake", 32'(f_ready), 32'd1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        check("BP accepted next cycle", 32'(f_busy), 32'd1);
        wait_valid(lat);
        check("BP MUL result", f_result, 32'd15);
        check("BP MUL latency", 32'(lat), 32'd33);
        @(posedge clk); #1;

        // Flush at T+10 of a divide
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk) flush_i = 1'b1;
        @(posedge clk); #1;
        check("flush ready_o", 32'(f_ready), 32'd1);
        check("flush busy_o", 32'(f_busy), 32'd0);
        flush_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (f_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("flush no valid_o", 32'(seen), 32'd0);

        // Flush in IDLE blocks a same-cycle accept
        @(negedge clk);
        flush_i = 1'b1; valid_i = 1'b1; op_i = OP_MUL; rs1_i = 32'd2; rs2_i = 32'd2;
        @(posedge clk); #1;
        check("idle flush blocks accept", 32'(f_busy), 32'd0);
        valid_i = 1'b0; flush_i = 1'b0;

        // Asynchronous reset in the middle of a multiply
        issue(OP_MUL, 32'd7, 32'd3);
        repeat (5) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("async rst valid_o", 32'(f_valid), 32'd0);
        check("async rst ready_o", 32'(f_ready), 32'd1);
        check("async rst busy_o", 32'(f_busy), 32'd0);
        check("async rst result_o", f_result, 32'd0);
        @(negedge clk) rst = 1'b0;
        run_op("MUL after rst", OP_MUL, 32'h0001_2345, 32'h0000_0010, 32'h0012_3450, 33);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
